// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: two-requester round-robin arbiter feeding a shared UART TX FIFO.
// A requester keeps the channel for a whole packet (until a beat with last=1).
// An idle counter releases the channel early if the granted requester stalls.
// Beats pass through a single registered output stage with one cycle of latency.
module uart_tx_arbiter #(
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 1024
) (
  input  logic              io_mainClk,
  input  logic              io_resetn,
  input  logic              s0_valid,
  input  logic [DATA_W-1:0] s0_data,
  input  logic              s0_last,
  output logic              s0_ready,
  input  logic              s1_valid,
  input  logic [DATA_W-1:0] s1_data,
  input  logic              s1_last,
  output logic              s1_ready,
  output logic              m_valid,
  output logic [DATA_W-1:0] m_data,
  input  logic              m_ready,
  output logic [1:0]        grant,
  output logic              timeout_pulse
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] GNT0 = 2'd1;
  localparam logic [1:0] GNT1 = 2'd2;

  // Counter value seen on the last allowed idle cycle of the owner.
  localparam logic [15:0] IDLE_LIMIT = 16'(TIMEOUT - 1);

  logic [1:0]        state;
  logic [1:0]        state_nxt;
  logic              rr_last;
  logic              rr_last_nxt;
  logic [15:0]       idle_cnt;
  logic [15:0]       idle_cnt_nxt;
  logic              timeout_nxt;

  logic              granted;
  logic              owner;
  logic              sel_valid;
  logic              sel_last;
  logic [DATA_W-1:0] sel_data;
  logic              out_free;
  logic              accept;

  // Owner-side mux, handshake and externally visible grant/ready.
  // Grant and ready are masked while reset is held so no beat can slip in.
  always_comb begin
    granted   = (state == GNT0) || (state == GNT1);
    owner     = (state == GNT1);
    sel_valid = owner ? s1_valid : s0_valid;
    sel_last  = owner ? s1_last  : s0_last;
    sel_data  = owner ? s1_data  : s0_data;
    out_free  = !m_valid || m_ready;
    accept    = io_resetn && granted && sel_valid && out_free;
    s0_ready  = io_resetn && (state == GNT0) && out_free;
    s1_ready  = io_resetn && (state == GNT1) && out_free;
    grant     = io_resetn ? {state == GNT1, state == GNT0} : 2'b00;
  end

  // Arbitration, packet lock and idle-timeout decisions.
  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves it
    // unassigned; otherwise synthesis infers a latch to hold the old value.
    state_nxt    = state;
    rr_last_nxt  = rr_last;
    idle_cnt_nxt = idle_cnt;
    timeout_nxt  = 1'b0;
    case (state)
      IDLE: begin
        // Counter is zero on every entry into a grant state.
        idle_cnt_nxt = '0;
        if (s0_valid && s1_valid) begin
          state_nxt = rr_last ? GNT0 : GNT1;
        end else if (s0_valid) begin
          state_nxt = GNT0;
        end else if (s1_valid) begin
          state_nxt = GNT1;
        end
      end
      GNT0, GNT1: begin
        if (accept) begin
          idle_cnt_nxt = '0;
          if (sel_last) begin
            state_nxt   = IDLE;
            rr_last_nxt = owner;
          end
        end else if (!sel_valid) begin
          idle_cnt_nxt = idle_cnt + 16'd1;
          if (idle_cnt == IDLE_LIMIT) begin
            state_nxt   = IDLE;
            rr_last_nxt = owner;
            timeout_nxt = 1'b1;
          end
        end
        // Valid but stalled by the output stage: counter holds.
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Control state registers with synchronous reset.
  always_ff @(posedge io_mainClk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (!io_resetn) begin
      state         <= IDLE;
      rr_last       <= 1'b1;
      idle_cnt      <= '0;
      timeout_pulse <= 1'b0;
    end else begin
      state         <= state_nxt;
      rr_last       <= rr_last_nxt;
      idle_cnt      <= idle_cnt_nxt;
      timeout_pulse <= timeout_nxt;
    end
  end

  // Output register: load on accept, clear valid on a consume without a load.
  always_ff @(posedge io_mainClk) begin
    // NOTE: the data register is reset too, so m_data reads a known zero after
    // reset; it is a single word, not a memory, so the reset costs little.
    if (!io_resetn) begin
      m_valid <= 1'b0;
      m_data  <= '0;
    end else if (accept) begin
      m_valid <= 1'b1;
      m_data  <= sel_data;
    end else if (m_ready) begin
      m_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Testbench for uart_tx_arbiter: a vector table for the basic contention
// sequence, hand-written multi-cycle corner cases, and randomized traffic
// checked by a per-requester scoreboard with packet-lock tracking.
module tb_uart_tx_arbiter;

  localparam int DATA_W  = 8;
  localparam int TIMEOUT = 8;
  localparam logic H = 1'b1;
  localparam logic L = 1'b0;

  logic              io_mainClk = 1'b0;
  logic              io_resetn;
  logic              s0_valid, s0_last, s1_valid, s1_last, m_ready;
  logic [DATA_W-1:0] s0_data, s1_data;
  logic              s0_ready, s1_ready, m_valid, timeout_pulse;
  logic [DATA_W-1:0] m_data;
  logic [1:0]        grant;

  uart_tx_arbiter #(.DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .io_mainClk    (io_mainClk),
    .io_resetn     (io_resetn),
    .s0_valid      (s0_valid),
    .s0_data       (s0_data),
    .s0_last       (s0_last),
    .s0_ready      (s0_ready),
    .s1_valid      (s1_valid),
    .s1_data       (s1_data),
    .s1_last       (s1_last),
    .s1_ready      (s1_ready),
    .m_valid       (m_valid),
    .m_data        (m_data),
    .m_ready       (m_ready),
    .grant         (grant),
    .timeout_pulse (timeout_pulse)
  );

  always #5 io_mainClk = ~io_mainClk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic next_cycle();
    @(negedge io_mainClk);
  endtask

  // Reset for two edges, check the reset state, release at a falling edge.
  task automatic do_reset();
    @(negedge io_mainClk);
    io_resetn = 1'b0;
    s0_valid = 1'b0; s0_data = '0; s0_last = 1'b0;
    s1_valid = 1'b0; s1_data = '0; s1_last = 1'b0;
    m_ready = 1'b0;
    @(negedge io_mainClk);
    #1;
    check("rst_grant", grant, 2'b00);
    check("rst_s0_ready", s0_ready, 1'b0);
    check("rst_s1_ready", s1_ready, 1'b0);
    check("rst_m_valid", m_valid, 1'b0);
    check("rst_m_data", m_data, 8'h00);
    check("rst_timeout", timeout_pulse, 1'b0);
    @(negedge io_mainClk);
    io_resetn = 1'b1;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic       s0_valid;
    logic [7:0] s0_data;
    logic       s0_last;
    logic       s1_valid;
    logic [7:0] s1_data;
    logic       s1_last;
    logic       m_ready;
    logic [1:0] e_grant;
    logic       e_s0_ready;
    logic       e_s1_ready;
    logic       e_mvalid;
    logic [7:0] e_mdata;
    logic       e_timeout;
  } vec_t;

  vec_t tbl[12];

  // ---------------- random traffic model ----------------
  typedef struct packed {
    logic [7:0] data;
    logic       last;
  } beat_t;

  beat_t      q0[$];
  beat_t      q1[$];
  logic       vld[2];
  logic [7:0] dat[2];
  logic       lst[2];
  int         left[2];
  logic [6:0] seq[2];
  bit         hs[2];
  bit         first[2];
  int         lock;
  int         prev_owner;
  bit         hold_prev;
  logic [7:0] hold_data;

  task automatic traffic_init();
    q0.delete();
    q1.delete();
    for (int r = 0; r < 2; r++) begin
      vld[r] = 1'b0; dat[r] = '0; lst[r] = 1'b0;
      left[r] = 0; seq[r] = '0; hs[r] = 1'b0; first[r] = 1'b0;
    end
    lock = -1;
    prev_owner = -1;
    hold_prev = 1'b0;
    hold_data = '0;
  endtask

  task automatic accept_beat(input int r);
    beat_t b;
    b.data = dat[r];
    b.last = lst[r];
    if (r == 0) q0.push_back(b);
    else        q1.push_back(b);
    left[r]  = left[r] - 1;
    seq[r]   = seq[r] + 7'd1;
    vld[r]   = 1'b0;
    first[r] = 1'b0;
  endtask

  task automatic present_beat(input int r, input int gap_pct, input int fixed_len, input bit drain);
    if (left[r] == 0) begin
      if (drain || ($urandom_range(99) < 32'(gap_pct))) return;
      left[r]  = (fixed_len > 0) ? fixed_len : int'($urandom_range(4, 1));
      first[r] = 1'b1;
    end else if ($urandom_range(99) < 32'(gap_pct)) begin
      return;
    end
    vld[r] = 1'b1;
    dat[r] = {r[0], seq[r]};
    lst[r] = (left[r] == 1);
  endtask

  task automatic observe(input bit alt_chk);
    beat_t e;
    hs[0] = s0_valid && s0_ready;
    hs[1] = s1_valid && s1_ready;
    check("grant_legal", grant != 2'b11, 1'b1);
    check("ready_excl", s0_ready && s1_ready, 1'b0);
    if (timeout_pulse) lock = -1;
    for (int r = 0; r < 2; r++) begin
      if (hs[r]) begin
        if (lock != -1) check("pkt_lock", r, lock);
        check("grant_src", grant, (r == 0) ? 2'b01 : 2'b10);
        if (alt_chk && first[r] && prev_owner != -1) check("alternate", r == prev_owner, 1'b0);
        if (first[r]) prev_owner = r;
        lock = lst[r] ? -1 : r;
      end
    end
    if (hold_prev) check("hold_data", m_data, hold_data);
    hold_prev = m_valid && !m_ready;
    hold_data = m_data;
    if (m_valid && m_ready) begin
      if (m_data[7] == 1'b0) begin
        check("out_pending0", q0.size() > 0, 1'b1);
        if (q0.size() > 0) begin
          e = q0.pop_front();
          check("out_order0", m_data, e.data);
        end
      end else begin
        check("out_pending1", q1.size() > 0, 1'b1);
        if (q1.size() > 0) begin
          e = q1.pop_front();
          check("out_order1", m_data, e.data);
        end
      end
    end
  endtask

  task automatic traffic(input int max_cycles, input int gap_pct, input int mready_pct,
                         input int fixed_len, input bit alt_chk, input bit drain);
    bit done;
    done = 1'b0;
    for (int c = 0; c < max_cycles && !done; c++) begin
      @(negedge io_mainClk);
      for (int r = 0; r < 2; r++) if (hs[r]) accept_beat(r);
      for (int r = 0; r < 2; r++) if (!vld[r]) present_beat(r, gap_pct, fixed_len, drain);
      s0_valid = vld[0]; s0_data = dat[0]; s0_last = lst[0];
      s1_valid = vld[1]; s1_data = dat[1]; s1_last = lst[1];
      m_ready  = ($urandom_range(99) < 32'(mready_pct));
      #1;
      observe(alt_chk);
      if (drain)
        done = (q0.size() == 0) && (q1.size() == 0) && !vld[0] && !vld[1] &&
               !hs[0] && !hs[1] && !m_valid;
    end
    if (drain) check("drain_done", done, 1'b1);
  endtask

  initial begin
    io_resetn = 1'b0;
    s0_valid = 1'b0; s0_data = '0; s0_last = 1'b0;
    s1_valid = 1'b0; s1_data = '0; s1_last = 1'b0;
    m_ready = 1'b0;

    // Both requesters contend from reset; s0 wins first, then s1, then s0 again.
    tbl[0]  = '{H, 8'hA1, L, H, 8'hB1, L, H, 2'b00, L, L, L, 8'h00, L};
    tbl[1]  = '{H, 8'hA1, L, H, 8'hB1, L, H, 2'b01, H, L, L, 8'h00, L};
    tbl[2]  = '{H, 8'hA2, L, H, 8'hB1, L, H, 2'b01, H, L, H, 8'hA1, L};
    tbl[3]  = '{H, 8'hA3, H, H, 8'hB1, L, H, 2'b01, H, L, H, 8'hA2, L};
    tbl[4]  = '{H, 8'hC1, H, H, 8'hB1, L, H, 2'b00, L, L, H, 8'hA3, L};
    tbl[5]  = '{H, 8'hC1, H, H, 8'hB1, L, H, 2'b10, L, H, L, 8'h00, L};
    tbl[6]  = '{H, 8'hC1, H, H, 8'hB2, L, H, 2'b10, L, H, H, 8'hB1, L};
    tbl[7]  = '{H, 8'hC1, H, H, 8'hB3, H, H, 2'b10, L, H, H, 8'hB2, L};
    tbl[8]  = '{H, 8'hC1, H, L, 8'h00, L, H, 2'b00, L, L, H, 8'hB3, L};
    tbl[9]  = '{H, 8'hC1, H, L, 8'h00, L, H, 2'b01, H, L, L, 8'h00, L};
    tbl[10] = '{L, 8'h00, L, L, 8'h00, L, H, 2'b00, L, L, H, 8'hC1, L};
    tbl[11] = '{L, 8'h00, L, L, 8'h00, L, H, 2'b00, L, L, L, 8'h00, L};

    do_reset();
    for (int i = 0; i < 12; i++) begin
      if (i > 0) next_cycle();
      s0_valid = tbl[i].s0_valid; s0_data = tbl[i].s0_data; s0_last = tbl[i].s0_last;
      s1_valid = tbl[i].s1_valid; s1_data = tbl[i].s1_data; s1_last = tbl[i].s1_last;
      m_ready  = tbl[i].m_ready;
      #1;
      check($sformatf("tbl%0d_grant", i), grant, tbl[i].e_grant);
      check($sformatf("tbl%0d_s0_ready", i), s0_ready, tbl[i].e_s0_ready);
      check($sformatf("tbl%0d_s1_ready", i), s1_ready, tbl[i].e_s1_ready);
      check($sformatf("tbl%0d_m_valid", i), m_valid, tbl[i].e_mvalid);
      check($sformatf("tbl%0d_timeout", i), timeout_pulse, tbl[i].e_timeout);
      if (tbl[i].e_mvalid) check($sformatf("tbl%0d_m_data", i), m_data, tbl[i].e_mdata);
    end

    // Long backpressure mid-packet: data held, ready low, no timeout, no loss.
    do_reset();
    s0_valid = 1'b1; s0_data = 8'hD1; s0_last = 1'b0; m_ready = 1'b1;
    #1;
    next_cycle(); #1;
    check("bp_accept_d1", s0_ready, 1'b1);
    next_cycle();
    s0_data = 8'hD2; m_ready = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (i > 0) next_cycle();
      #1;
      check("bp_m_valid", m_valid, 1'b1);
      check("bp_m_data", m_data, 8'hD1);
      check("bp_s0_ready", s0_ready, 1'b0);
      check("bp_timeout", timeout_pulse, 1'b0);
      check("bp_grant", grant, 2'b01);
    end
    next_cycle(); m_ready = 1'b1; #1;
    check("bp_release_ready", s0_ready, 1'b1);
    check("bp_release_data", m_data, 8'hD1);
    next_cycle(); s0_data = 8'hD3; #1;
    check("bp_d2", m_data, 8'hD2);
    next_cycle(); s0_data = 8'hD4; s0_last = 1'b1; #1;
    check("bp_d3", m_data, 8'hD3);
    next_cycle(); s0_valid = 1'b0; s0_last = 1'b0; #1;
    check("bp_d4", m_data, 8'hD4);
    check("bp_d4_valid", m_valid, 1'b1);
    check("bp_end_grant", grant, 2'b00);

    // Timeout: s1 sends one non-last beat then stalls; output stays blocked
    // so the pending beat must still drain after the forced release.
    do_reset();
    m_ready = 1'b0;
    s1_valid = 1'b1; s1_data = 8'hE1; s1_last = 1'b0;
    #1;
    next_cycle(); #1;
    check("to_accept", s1_ready, 1'b1);
    check("to_grant1", grant, 2'b10);
    for (int k = 1; k <= 9; k++) begin
      next_cycle();
      if (k == 1) begin
        s1_valid = 1'b0;
        s0_valid = 1'b1; s0_data = 8'hF1; s0_last = 1'b1;
      end
      #1;
      check($sformatf("to_pulse_k%0d", k), timeout_pulse, k == 9);
      check($sformatf("to_grant_k%0d", k), grant, (k == 9) ? 2'b00 : 2'b10);
      check($sformatf("to_mvalid_k%0d", k), m_valid, 1'b1);
      check($sformatf("to_mdata_k%0d", k), m_data, 8'hE1);
      if (k == 1) check("to_s0_blocked", s0_ready, 1'b0);
    end
    next_cycle(); m_ready = 1'b1; #1;
    check("to_next_grant", grant, 2'b01);
    check("to_pulse_gone", timeout_pulse, 1'b0);
    check("to_s0_ready", s0_ready, 1'b1);
    check("to_drain_e1", m_data, 8'hE1);
    next_cycle(); s0_valid = 1'b0; s0_last = 1'b0; #1;
    check("to_f1_data", m_data, 8'hF1);
    check("to_f1_valid", m_valid, 1'b1);
    check("to_f1_grant", grant, 2'b00);

    // Reset pulse during beat 2 of an s0 packet while s1 also waits.
    do_reset();
    m_ready = 1'b1;
    s0_valid = 1'b1; s0_data = 8'h61; s0_last = 1'b0;
    s1_valid = 1'b1; s1_data = 8'h71; s1_last = 1'b0;
    #1;
    next_cycle(); #1;
    check("mr_grant0", grant, 2'b01);
    check("mr_accept1", s0_ready, 1'b1);
    next_cycle(); s0_data = 8'h62; io_resetn = 1'b0; #1;
    check("mr_rst_grant", grant, 2'b00);
    check("mr_rst_s0_ready", s0_ready, 1'b0);
    check("mr_rst_s1_ready", s1_ready, 1'b0);
    next_cycle(); io_resetn = 1'b1; #1;
    check("mr_after_mvalid", m_valid, 1'b0);
    check("mr_after_grant", grant, 2'b00);
    check("mr_after_s0_ready", s0_ready, 1'b0);
    check("mr_after_s1_ready", s1_ready, 1'b0);
    check("mr_after_timeout", timeout_pulse, 1'b0);
    next_cycle(); #1;
    check("mr_fresh_grant", grant, 2'b01);
    check("mr_fresh_ready", s0_ready, 1'b1);

    // Continuous 2-beat packets from both sides: strict packet alternation.
    do_reset();
    traffic_init();
    traffic(80, 0, 100, 2, 1'b1, 1'b0);
    traffic(300, 0, 100, 0, 1'b0, 1'b1);

    // Random traffic with gaps and backpressure, then heavier gaps that
    // occasionally trigger timeouts mid-packet.
    traffic(3000, 30, 70, 0, 1'b0, 1'b0);
    traffic(300, 0, 100, 0, 1'b0, 1'b1);
    traffic(3000, 60, 60, 0, 1'b0, 1'b0);
    traffic(300, 0, 100, 0, 1'b0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
